// File: rtl/alu_seq.sv
// alu_seq: registered, WIDTH-parametrised ALU with a valid/ready request side.
// Executes the 5-bit FunSel op set in full or half width. The result, the
// out_valid pulse and the {Z,C,N,V} flag register update one cycle after
// acceptance.
// Optional feature macro: ALU_SHIFT_MULTI_EN. When it is defined, shifts and
// rotates move by input_b bits through an iterative SHIFT state. When it is
// undefined, they move by exactly one bit in a single cycle.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       FunSel,
    input  logic             flag_wen,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       flags
);

    localparam int HALF = WIDTH / 2;
    localparam int SW   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] LO_MASK = {{HALF{1'b0}}, {HALF{1'b1}}};

    localparam logic [3:0] OP_A    = 4'h0;
    localparam logic [3:0] OP_B    = 4'h1;
    localparam logic [3:0] OP_NA   = 4'h2;
    localparam logic [3:0] OP_NB   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_ADC  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_LSL  = 4'hB;
    localparam logic [3:0] OP_LSR  = 4'hC;
    localparam logic [3:0] OP_ASR  = 4'hD;
    localparam logic [3:0] OP_CSL  = 4'hE;
    localparam logic [3:0] OP_CSR  = 4'hF;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    // Clear the upper half in half mode. Every operand and intermediate is kept
    // in this form, so carry and shift-out logic never sees stale upper bits.
    function automatic logic [WIDTH-1:0] opmask(input logic [WIDTH-1:0] v, input logic full);
        if (full) return v;
        else      return v & LO_MASK;
    endfunction

    // Widen an operating-width value to WIDTH bits. Half mode sign-extends from bit HALF-1.
    function automatic logic [WIDTH-1:0] ext(input logic [WIDTH-1:0] v, input logic full);
        if (full) return v;
        else      return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
    endfunction

    // Return the sign bit at the operating width.
    function automatic logic msb_of(input logic [WIDTH-1:0] v, input logic full);
        if (full) return v[WIDTH-1];
        else      return v[HALF-1];
    endfunction

    // Shift or rotate by one bit. Returns {bit shifted out, masked result}.
    function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] v, input logic full,
                                              input logic [3:0] op, input logic cin);
        logic [WIDTH-1:0] r;
        logic             co;
        logic             top;
        top = msb_of(v, full);
        r   = v;
        co  = cin;
        case (op)
            OP_LSL: begin r = v << 1; co = top; end
            OP_LSR: begin r = v >> 1; co = v[0]; end
            OP_ASR: begin
                r  = v >> 1;
                co = v[0];
                if (full) r[WIDTH-1] = top;
                else      r[HALF-1]  = top;
            end
            OP_CSL: begin r = (v << 1) | {{(WIDTH-1){1'b0}}, cin}; co = top; end
            OP_CSR: begin
                r  = v >> 1;
                co = v[0];
                if (full) r[WIDTH-1] = cin;
                else      r[HALF-1]  = cin;
            end
            default: begin r = v; co = cin; end
        endcase
        return {co, opmask(r, full)};
    endfunction

    state_t           state_r, state_nx;
    logic             ready_r;
    logic             accept_s, start_shift_s, shift_done_s;
    logic [WIDTH-1:0] a_r, b_r;
    logic [4:0]       fun_r;
    logic             fw_r, pend_r;
    logic [WIDTH-1:0] alu_out_r;
    logic [3:0]       flags_r;
    logic             out_valid_r;

    logic             full_s, cin_s, add_c_s, carry_s, co_s, sa_s, sb_s, sr_s, v_s;
    logic [3:0]       op_s;
    logic [WIDTH-1:0] add_b_s, res_s, exec_res_s;
    logic [WIDTH:0]   sum_s;
    logic [3:0]       exec_flags_s;

`ifdef ALU_SHIFT_MULTI_EN
    localparam logic [SW-1:0] CNT_ONE = {{(SW-1){1'b0}}, 1'b1};
    logic             is_shift_op_s;
    logic [SW-1:0]    n_in_s, cnt_r;
    logic [WIDTH-1:0] work_r;
    logic             cwork_r, first_r;
    logic             sh_cin_s, sh_co_s;
    logic [WIDTH-1:0] sh_val_s;
`else
    logic [WIDTH:0]   sh1_s;
`endif

    assign in_ready  = ready_r;
    assign out_valid = out_valid_r;
    assign ALUOut    = alu_out_r;
    assign flags     = flags_r;

    // State register; in_ready is registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nx;
            ready_r <= (state_nx == S_IDLE);
        end
    end

    // Next-state logic: enter SHIFT on a multi-bit shift, leave when the count expires.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_shift_s) state_nx = S_SHIFT;
                else               state_nx = S_IDLE;
            end
            S_SHIFT: begin
                if (shift_done_s) state_nx = S_IDLE;
                else              state_nx = S_SHIFT;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Control decode: accept, shift start and shift completion.
    always_comb begin
        accept_s = in_valid && ready_r;
`ifdef ALU_SHIFT_MULTI_EN
        is_shift_op_s = (FunSel[3:0] >= OP_LSL);
        if (FunSel[4]) n_in_s = input_b[SW-1:0];
        else           n_in_s = {1'b0, input_b[SW-2:0]};
        start_shift_s = accept_s && is_shift_op_s && (n_in_s != {SW{1'b0}});
        shift_done_s  = (state_r == S_SHIFT) && (cnt_r == CNT_ONE);
`else
        start_shift_s = 1'b0;
        shift_done_s  = 1'b0;
`endif
    end

    // Single-cycle execute: result and flags of the captured op. Carry-in is read
    // from the live flag register, so an op issued back-to-back after a
    // flag-writing op sees that op's carry.
    always_comb begin
        full_s  = fun_r[4];
        op_s    = fun_r[3:0];
        cin_s   = flags_r[2];
        add_b_s = b_r;
        add_c_s = 1'b0;
        if (op_s == OP_ADC) begin
            add_c_s = cin_s;
        end else if (op_s == OP_SUB) begin
            add_b_s = opmask(~b_r, full_s);
            add_c_s = 1'b1;
        end else begin
            add_b_s = b_r;
            add_c_s = 1'b0;
        end
        sum_s   = {1'b0, a_r} + {1'b0, add_b_s} + {{WIDTH{1'b0}}, add_c_s};
        carry_s = full_s ? sum_s[WIDTH] : sum_s[HALF];
        res_s   = a_r;
        co_s    = cin_s;
`ifndef ALU_SHIFT_MULTI_EN
        sh1_s   = shift1(a_r, full_s, op_s, cin_s);
`endif
        case (op_s)
            OP_A:    res_s = a_r;
            OP_B:    res_s = b_r;
            OP_NA:   res_s = opmask(~a_r, full_s);
            OP_NB:   res_s = opmask(~b_r, full_s);
            OP_ADD, OP_ADC, OP_SUB: begin
                res_s = opmask(sum_s[WIDTH-1:0], full_s);
                co_s  = carry_s;
            end
            OP_AND:  res_s = a_r & b_r;
            OP_OR:   res_s = a_r | b_r;
            OP_XOR:  res_s = a_r ^ b_r;
            OP_NAND: res_s = opmask(~(a_r & b_r), full_s);
            OP_LSL, OP_LSR, OP_ASR, OP_CSL, OP_CSR: begin
`ifdef ALU_SHIFT_MULTI_EN
                // Only zero-distance shifts reach this path: pass A, keep C.
                res_s = a_r;
                co_s  = cin_s;
`else
                res_s = sh1_s[WIDTH-1:0];
                co_s  = sh1_s[WIDTH];
`endif
            end
            default: begin
                res_s = a_r;
                co_s  = cin_s;
            end
        endcase
        sa_s = msb_of(a_r, full_s);
        sb_s = msb_of(b_r, full_s);
        sr_s = msb_of(res_s, full_s);
        if (op_s == OP_ADD || op_s == OP_ADC) v_s = (sa_s == sb_s) && (sr_s != sa_s);
        else if (op_s == OP_SUB)              v_s = (sa_s != sb_s) && (sr_s != sa_s);
        else                                  v_s = 1'b0;
        exec_flags_s = {(res_s == {WIDTH{1'b0}}), co_s, sr_s, v_s};
        exec_res_s   = ext(res_s, full_s);
    end

`ifdef ALU_SHIFT_MULTI_EN
    // One shift step. On the first step, rotate-through-carry takes C from the flag register.
    always_comb begin
        if (first_r) sh_cin_s = flags_r[2];
        else         sh_cin_s = cwork_r;
        {sh_co_s, sh_val_s} = shift1(work_r, fun_r[4], fun_r[3:0], sh_cin_s);
    end

    // Iterative shifter: load on start, step once per cycle while in SHIFT.
    always_ff @(posedge clock) begin
        if (reset) begin
            work_r  <= {WIDTH{1'b0}};
            cnt_r   <= {SW{1'b0}};
            cwork_r <= 1'b0;
            first_r <= 1'b0;
        end else if (start_shift_s) begin
            work_r  <= opmask(input_a, FunSel[4]);
            cnt_r   <= n_in_s;
            first_r <= 1'b1;
        end else if (state_r == S_SHIFT) begin
            work_r  <= sh_val_s;
            cwork_r <= sh_co_s;
            cnt_r   <= cnt_r - CNT_ONE;
            first_r <= 1'b0;
        end
    end
`endif

    // Operand capture on accept, then registered result, flags and out_valid pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            fun_r       <= 5'b00000;
            fw_r        <= 1'b0;
            pend_r      <= 1'b0;
            alu_out_r   <= {WIDTH{1'b0}};
            flags_r     <= 4'b0000;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (pend_r) begin
                alu_out_r   <= exec_res_s;
                out_valid_r <= 1'b1;
                if (fw_r) flags_r <= exec_flags_s;
            end
`ifdef ALU_SHIFT_MULTI_EN
            if (shift_done_s) begin
                alu_out_r   <= ext(sh_val_s, fun_r[4]);
                out_valid_r <= 1'b1;
                if (fw_r) flags_r <= {(sh_val_s == {WIDTH{1'b0}}), sh_co_s,
                                      msb_of(sh_val_s, fun_r[4]), 1'b0};
            end
`endif
            pend_r <= accept_s && !start_shift_s;
            if (accept_s) begin
                a_r   <= opmask(input_a, FunSel[4]);
                b_r   <= opmask(input_b, FunSel[4]);
                fun_r <= FunSel;
                fw_r  <= flag_wen;
            end
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's fixed 32-bit ALU. It executes the same 5-bit FunSel operation set at a configurable WIDTH, in full or half width, behind a valid/ready handshake. Flags are computed from the current result, not the previous one, and are written only on request. With the optional feature enabled, shift and rotate ops become multi-bit and run iteratively. It sits between the register file read ports and the writeback/flag register path of the datapath.

## Interface
- WIDTH, 32, full operand width; even, ≥ 8. HALF = WIDTH/2.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high when a request can be accepted (state IDLE).
- FunSel  in  5  bit 4: 1 = full width, 0 = half width; bits 3:0 = opcode.
- flag_wen  in  1  update flags on completion of this op.
- input_a  in  WIDTH  operand A.
- input_b  in  WIDTH  operand B; also the shift amount.
- out_valid  out  1  one-cycle pulse when ALUOut holds a new result.
- ALUOut  out  WIDTH  registered result.
- flags  out  4  {Z,C,N,V} register.

## Operation
- Opcodes 0–F, in order: A, B, ~A, ~B, A+B, A+B+C, A−B, A&B, A|B, A^B, ~(A&B), LSL, LSR, ASR, CSL (rotate left through C), CSR (rotate right through C).
- Acceptance: an op is accepted on a cycle with in_valid && in_ready. Operands, FunSel and flag_wen are captured at that edge.
- Half mode: the op uses bits [HALF-1:0] of each operand; the result is sign-extended from bit HALF-1 to WIDTH. Carry is taken from bit HALF; shifts and rotates act on HALF bits only.
- C input for ops 5, E, F is flags.C at the accept edge. This value already reflects the previous op's update, so ADC chains work back-to-back.
- Subtract is computed as A + ~B + 1. C = carry out, i.e. 1 when A ≥ B unsigned at the operating width.
- Z: result at the operating width == 0.
- N: sign bit of the result at the operating width.
- V for add/adc: operand signs equal and result sign differs. For sub: operand signs differ and result sign ≠ A sign. V = 0 for all other ops.
- C for logic/move ops: unchanged. C for shifts/rotates: the last bit shifted out.
- Flag write: flags are written on the completion cycle only if the captured flag_wen = 1. Otherwise flags hold.
- States: IDLE, SHIFT.
  - Single-cycle op: stays in IDLE.
  - Multi-bit shift with n > 0: IDLE → SHIFT. The counter is loaded with n, one bit is shifted per cycle, and the state returns to IDLE on the cycle the counter reaches 0.
- Requests during SHIFT are not accepted (in_ready = 0). There is no output backpressure; the consumer must take ALUOut on the out_valid pulse.

## Timing
- Reset values: ALUOut = 0, flags = 4'b0000, out_valid = 0, state IDLE, in_ready = 1.
- Single-cycle op accepted at edge t: ALUOut, flags and the out_valid pulse are all visible after edge t+1.
- Back-to-back single-cycle ops are allowed every cycle.
- Multi-bit shift with n > 0, accepted at t:
  - in_ready is low for n cycles.
  - out_valid appears after edge t+n.
  - The next op can be accepted on the edge after out_valid.
- Shift amount n = input_b[log2(W)-1:0], where W is the operating width. Higher bits are ignored, so the amount wraps modulo W. n = 0 completes in one cycle with result = A (extended), C unchanged, V = 0.
- Reset during SHIFT aborts the op: no out_valid is produced, flags are not updated, and the block returns to reset values on the next edge.

## Configuration
- ALU_SHIFT_MULTI_EN defined: ops B–F shift/rotate by n bits using the iterative SHIFT state, with latency as above.
- ALU_SHIFT_MULTI_EN undefined: ops B–F shift/rotate by exactly 1 bit in one cycle. input_b is ignored for these ops, the SHIFT state is not built, and in_ready is constantly 1 outside reset.

## Test plan
- Reset, then FunSel=10100, A=0xFFFFFFFF, B=1, flag_wen=1 → next cycle: out_valid=1, ALUOut=0x00000000, flags=4'b1100.
- FunSel=10100, A=0x7FFFFFFF, B=1 → ALUOut=0x80000000, flags=4'b0011.
- The op above with A=0xFFFFFFFF, B=1 (C=1), immediately followed by FunSel=10101, A=0, B=0 → second result 0x00000001. A following op with flag_wen=0 leaves flags unchanged.
- Half mode, FunSel=00110, A=0x00000005, B=0x00000007 → ALUOut=0xFFFFFFFE, flags=4'b0010.
- With ALU_SHIFT_MULTI_EN: FunSel=11011, A=0x00000001, B=0x24 (n=4) → in_ready low 4 cycles, in_valid pulses during busy are ignored, ALUOut=0x00000010, C=0. Repeat and assert reset on cycle 2 → no out_valid, flags=0.
- Without ALU_SHIFT_MULTI_EN: FunSel=11110, A=0x80000000, C=1 → one cycle, ALUOut=0x00000001, C=1.
